exm_stage: RTL

EXM_STAGE -- requirements
Module: exm_stage

---
 rtl/exm_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/exm_stage.sv
// -----------------------------------------------------------------------------
// exm_stage -- EX/MEM pipeline register built as a 2-entry elastic buffer.
//
// The buffer has two registers:
//   OUT  : drives every M-side output.
//   SKID : catches one extra entry when MEM stalls while EX is still sending.
// ready_out is decoded from registered state only. It therefore has no
// combinational path from ready_in.
//
// Ports
//   clk        : clock, all state updates on posedge
//   rst        : synchronous active-low reset
//   flush      : discard all held entries and any simultaneous accept
//   valid_in   : EX-side entry valid
//   ready_out  : stage can accept an entry this cycle
//   ILoadE, WBSelE, RegWEnE, MemRWE         : EX-side control fields
//   ALUOutE, RS2E, PCPlus4E, RdE            : EX-side data fields
//   valid_out  : MEM-side entry valid
//   ready_in   : MEM stage consumes the OUT entry this cycle
//   ILoadM, WBSelM, RegWEnM, MemRWM,
//   ALUOutM, RS2M, PCPlus4M, RdM            : registered MEM-side fields
// -----------------------------------------------------------------------------
module exm_stage #(
   parameter int WIDTH = 5,
   parameter int XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [2:0]       ILoadE,
   input  logic [1:0]       WBSelE,
   input  logic             RegWEnE,
   input  logic             MemRWE,
   input  logic [XLEN-1:0]  ALUOutE,
   input  logic [XLEN-1:0]  RS2E,
   input  logic [XLEN-1:0]  PCPlus4E,
   input  logic [WIDTH-1:0] RdE,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [2:0]       ILoadM,
   output logic [1:0]       WBSelM,
   output logic             RegWEnM,
   output logic             MemRWM,
   output logic [XLEN-1:0]  ALUOutM,
   output logic [XLEN-1:0]  RS2M,
   output logic [XLEN-1:0]  PCPlus4M,
   output logic [WIDTH-1:0] RdM
);

   // Entry layout, LSB first: Rd | PCPlus4 | RS2 | ALUOut | MemRW | RegWEn | WBSel | ILoad
   localparam int ENTRY_W = 7 + 3*XLEN + WIDTH;
   localparam int PC_LSB  = WIDTH;
   localparam int RS2_LSB = WIDTH + XLEN;
   localparam int ALU_LSB = WIDTH + 2*XLEN;
   localparam int MRW_BIT = WIDTH + 3*XLEN;
   localparam int RWE_BIT = WIDTH + 3*XLEN + 1;
   localparam int WBS_LSB = WIDTH + 3*XLEN + 2;
   localparam int ILD_LSB = WIDTH + 3*XLEN + 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t               state_r;
   logic [ENTRY_W-1:0]   out_r;
   logic [ENTRY_W-1:0]   skid_r;
   logic                 valid_out_r;
   logic                 ready_out_r;
   logic [ENTRY_W-1:0]   entry_in_s;
   logic                 accept_s;
   logic                 drain_s;

   // Clear the two side-effecting enables of an entry. A bubble in OUT must
   // never write the register file or memory. The other fields are left unchanged.
   function automatic logic [ENTRY_W-1:0] kill_writes(input logic [ENTRY_W-1:0] e);
      logic [ENTRY_W-1:0] r;
      r          = e;
      r[RWE_BIT] = 1'b0;
      r[MRW_BIT] = 1'b0;
      return r;
   endfunction

   // Pack the incoming EX fields into one entry so that they always move together.
   always_comb begin
      entry_in_s = {ILoadE, WBSelE, RegWEnE, MemRWE, ALUOutE, RS2E, PCPlus4E, RdE};
   end

   // Handshake decode. Both terms come from registered flags only.
   always_comb begin
      accept_s = valid_in & ready_out_r;
      drain_s  = valid_out_r & ready_in;
   end

   // Buffer control and storage. The valid and ready flags are registered next to the state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= EMPTY;
         out_r       <= {ENTRY_W{1'b0}};
         skid_r      <= {ENTRY_W{1'b0}};
         valid_out_r <= 1'b0;
         ready_out_r <= 1'b1;
      end else if (flush) begin
         state_r     <= EMPTY;
         out_r       <= kill_writes(out_r);
         valid_out_r <= 1'b0;
         ready_out_r <= 1'b1;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept_s) begin
                  out_r       <= entry_in_s;
                  state_r     <= ONE;
                  valid_out_r <= 1'b1;
                  ready_out_r <= 1'b1;
               end else begin
                  state_r     <= EMPTY;
               end
            end
            ONE: begin
               if (accept_s && drain_s) begin
                  out_r       <= entry_in_s;
               end else if (accept_s) begin
                  skid_r      <= entry_in_s;
                  state_r     <= FULL;
                  ready_out_r <= 1'b0;
               end else if (drain_s) begin
                  out_r       <= kill_writes(out_r);
                  state_r     <= EMPTY;
                  valid_out_r <= 1'b0;
               end else begin
                  state_r     <= ONE;
               end
            end
            FULL: begin
               // ready_out is 0 here, so no accept can coincide with the drain.
               if (drain_s) begin
                  out_r       <= skid_r;
                  state_r     <= ONE;
                  ready_out_r <= 1'b1;
               end else begin
                  state_r     <= FULL;
               end
            end
            default: begin
               state_r     <= EMPTY;
               out_r       <= kill_writes(out_r);
               valid_out_r <= 1'b0;
               ready_out_r <= 1'b1;
            end
         endcase
      end
   end

   assign valid_out = valid_out_r;
   assign ready_out = ready_out_r;
   assign ILoadM    = out_r[ILD_LSB +: 3];
   assign WBSelM    = out_r[WBS_LSB +: 2];
   assign RegWEnM   = out_r[RWE_BIT];
   assign MemRWM    = out_r[MRW_BIT];
   assign ALUOutM   = out_r[ALU_LSB +: XLEN];
   assign RS2M      = out_r[RS2_LSB +: XLEN];
   assign PCPlus4M  = out_r[PC_LSB +: XLEN];
   assign RdM       = out_r[WIDTH-1:0];

endmodule
